// File: rtl/bus_timer_pkg.sv
// Shared register offsets, state codes and CTRL layout for the bus timer.
package bus_timer_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  localparam logic [1:0] TC_ONESHOT = 2'b00;
  localparam logic [1:0] TC_AUTO    = 2'b01;

  localparam int TC_EN_BIT = 0;
  localparam int TC_IM_BIT = 3;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Field order matches the CTRL bit positions: IM=3, MODE=2:1, EN=0.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

endpackage

// File: rtl/bus_timer_if.sv
// M-stage data-bus slice seen by the timer: store/load request plus irq.
interface bus_timer_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, byteen, wdata, input rdata, irq);
  modport slave  (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit down-counter with one-shot / auto-reload modes and a
// maskable interrupt. Address window decoding is done by the bridge.
module bus_timer
  import bus_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  bus_timer_if.slave  bus
);

  tc_ctrl_t    ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  tc_state_e   state;
  logic        irq_flag;

  logic [1:0]  off;
  logic        wr_ctrl_any;
  logic        wr_ctrl_b0;
  logic        wr_preset;
  logic [31:0] ctrl_merged;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign off         = bus.addr[3:2];
  assign wr_ctrl_any = bus.we && (off == TC_CTRL) && (|bus.byteen);
  // Only lane 0 carries implemented CTRL bits.
  assign wr_ctrl_b0  = bus.we && (off == TC_CTRL) && bus.byteen[0];
  assign wr_preset   = bus.we && (off == TC_PRESET);
  assign ctrl_merged = merge_bytes({28'h0, ctrl}, bus.wdata, bus.byteen);

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], ctrl_merged[31:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= TC_IDLE;
      irq_flag <= 1'b0;
    end else begin
      if (wr_preset) preset <= merge_bytes(preset, bus.wdata, bus.byteen);

      case (state)
        TC_IDLE: if (ctrl.en) state <= TC_LOAD;
        TC_LOAD: begin
          count <= preset;
          state <= TC_CNT;
        end
        TC_CNT: begin
          if (!ctrl.en) begin
            state <= TC_IDLE;
          end else if (count == 32'd0) begin
            state    <= TC_INT;
            irq_flag <= 1'b1;
          end else begin
            count <= count - 32'd1;
          end
        end
        TC_INT: begin
          if (ctrl.mode == TC_AUTO) begin
            state    <= TC_LOAD;
            irq_flag <= 1'b0;
          end else begin
            ctrl.en <= 1'b0;
            state   <= TC_IDLE;
          end
        end
        default: state <= TC_IDLE;
      endcase

      // Bus stores are placed last so they override the FSM's EN clear and
      // irq_flag set in the same cycle.
      if (wr_ctrl_b0)  ctrl     <= tc_ctrl_t'(ctrl_merged[3:0]);
      if (wr_ctrl_any) irq_flag <= 1'b0;
    end
  end

  assign bus.irq = ctrl.im & irq_flag;

  always_comb begin
    bus.rdata = 32'h0;
    case (off)
      TC_CTRL:   bus.rdata = {28'h0, ctrl};
      TC_PRESET: bus.rdata = preset;
      TC_COUNT:  bus.rdata = count;
      default:   bus.rdata = 32'h0;
    endcase
  end

endmodule
